// File: rtl/alarm_pkg.sv
// Shared state encoding and display-select codes for the alarm clock sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_SET    = 3'd2,
    ST_RING   = 3'd3,
    ST_SNOOZE = 3'd4
  } state_t;

  localparam logic [1:0] DISP_TIME = 2'b00;
  localparam logic [1:0] DISP_SET  = 2'b01;
  localparam logic [1:0] DISP_RING = 2'b10;
  localparam logic [1:0] DISP_SNZ  = 2'b11;

  function automatic logic [1:0] disp_code(input state_t s);
    case (s)
      ST_SET:    disp_code = DISP_SET;
      ST_RING:   disp_code = DISP_RING;
      ST_SNOOZE: disp_code = DISP_SNZ;
      default:   disp_code = DISP_TIME;
    endcase
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable up/down seconds counter; counts ring time up and snooze time down.
module alarm_sec_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             up,
  input  logic             dn,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Priority clr > load > up > dn; both directions saturate.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (up && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dn && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign term = (cnt == term_val);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: alarm detection, ringing with timeout, limited snooze, set mode.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int CNT_W          = 9,
  parameter int SNZ_W          = $clog2(MAX_SNOOZE + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_1s_i,
  input  logic [4:0]       cur_hh_i,
  input  logic [5:0]       cur_mm_i,
  input  logic [4:0]       alm_hh_i,
  input  logic [5:0]       alm_mm_i,
  input  logic             alm_en_i,
  input  logic             set_req_i,
  input  logic             snooze_i,
  input  logic             stop_i,
  output logic [1:0]       disp_sel_o,
  output logic             ring_o,
  output logic [CNT_W-1:0] snz_left_o,
  output state_t           dbg_state,
  output logic [SNZ_W-1:0] dbg_snz_cnt
);

  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_S);
  localparam logic [CNT_W-1:0] SNZ_LAST  = CNT_W'(1);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  state_t           state_q, state_d;
  logic             phase_q, phase_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             match, match_q, trigger;
  logic [1:0]       disp_q;
  logic             ring_q;

  logic             tmr_clr, tmr_load, tmr_up, tmr_dn, tmr_term;
  logic [CNT_W-1:0] tmr_term_val, tmr_cnt;

  assign match   = alm_en_i & (cur_hh_i == alm_hh_i) & (cur_mm_i == alm_mm_i);
  assign trigger = match & ~match_q;

  alarm_sec_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (SNZ_LOAD),
    .up       (tmr_up),
    .dn       (tmr_dn),
    .term_val (tmr_term_val),
    .cnt      (tmr_cnt),
    .term     (tmr_term)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    snz_cnt_d    = snz_cnt_q;
    tmr_clr      = 1'b0;
    tmr_load     = 1'b0;
    tmr_up       = 1'b0;
    tmr_dn       = 1'b0;
    tmr_term_val = (state_q == ST_SNOOZE) ? SNZ_LAST : RING_LAST;
    unique case (state_q)
      ST_IDLE: begin
        if (alm_en_i)       state_d = ST_ARMED;
        else if (set_req_i) state_d = ST_SET;
      end
      ST_ARMED: begin
        if (!alm_en_i)      state_d = ST_IDLE;
        else if (set_req_i) state_d = ST_SET;
        else if (trigger) begin
          state_d = ST_RING;
          tmr_clr = 1'b1;
          phase_d = 1'b1;
        end
      end
      ST_SET: begin
        if (set_req_i) state_d = alm_en_i ? ST_ARMED : ST_IDLE;
      end
      // A button that changes state consumes a coincident tick.
      ST_RING: begin
        if (!alm_en_i)   state_d = ST_IDLE;
        else if (stop_i) state_d = ST_ARMED;
        else if (snooze_i && (snz_cnt_q < SNZ_MAX)) begin
          state_d   = ST_SNOOZE;
          snz_cnt_d = snz_cnt_q + 1'b1;
          tmr_load  = 1'b1;
        end else if (tick_1s_i) begin
          if (tmr_term) begin
            state_d = ST_ARMED;
          end else begin
            tmr_up  = 1'b1;
            phase_d = ~phase_q;
          end
        end
      end
      ST_SNOOZE: begin
        if (!alm_en_i)   state_d = ST_IDLE;
        else if (stop_i) state_d = ST_ARMED;
        else if (tick_1s_i) begin
          if (tmr_term) begin
            state_d = ST_RING;
            tmr_clr = 1'b1;
            phase_d = 1'b1;
          end else begin
            tmr_dn = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_ARMED) || (state_d == ST_IDLE)) begin
      snz_cnt_d = '0;
      tmr_clr   = 1'b1;
      phase_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      snz_cnt_q <= '0;
      match_q   <= 1'b0;
      disp_q    <= DISP_TIME;
      ring_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      snz_cnt_q <= snz_cnt_d;
      match_q   <= match;
      disp_q    <= disp_code(state_d);
      ring_q    <= (state_d == ST_RING) & phase_d;
    end
  end

  assign disp_sel_o  = disp_q;
  assign ring_o      = ring_q;
  assign snz_left_o  = (state_q == ST_SNOOZE) ? tmr_cnt : '0;
  assign dbg_state   = state_q;
  assign dbg_snz_cnt = snz_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus random stimulus against a behavioural model.
module tb_alarm_sequencer;
  import alarm_pkg::*;

  localparam int RT = 4;
  localparam int SS = 3;
  localparam int MS = 2;
  localparam int CW = 9;

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          tick_1s_i = 1'b0;
  logic [4:0]    cur_hh_i = '0, alm_hh_i = '0;
  logic [5:0]    cur_mm_i = '0, alm_mm_i = '0;
  logic          alm_en_i = 1'b0, set_req_i = 1'b0, snooze_i = 1'b0, stop_i = 1'b0;
  logic [1:0]    disp_sel_o;
  logic          ring_o;
  logic [CW-1:0] snz_left_o;
  state_t        dbg_state;
  logic [1:0]    dbg_snz_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alarm_sequencer #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SS), .MAX_SNOOZE(MS), .CNT_W(CW)) dut (
    .clk_in(clk_in), .rst(rst), .tick_1s_i(tick_1s_i),
    .cur_hh_i(cur_hh_i), .cur_mm_i(cur_mm_i), .alm_hh_i(alm_hh_i), .alm_mm_i(alm_mm_i),
    .alm_en_i(alm_en_i), .set_req_i(set_req_i), .snooze_i(snooze_i), .stop_i(stop_i),
    .disp_sel_o(disp_sel_o), .ring_o(ring_o), .snz_left_o(snz_left_o),
    .dbg_state(dbg_state), .dbg_snz_cnt(dbg_snz_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: what the user sees, in seconds rung, seconds left and snoozes used.
  typedef enum int {M_IDLE, M_ARMED, M_SET, M_RING, M_SNOOZE} mode_t;
  mode_t m_mode;
  int    m_rung, m_left, m_snoozes;
  bit    m_bell, m_prev_match;

  task automatic model_reset();
    m_mode = M_IDLE; m_rung = 0; m_left = 0; m_snoozes = 0; m_bell = 0; m_prev_match = 0;
  endtask

  task automatic go_quiet(input mode_t m);
    m_mode = m; m_rung = 0; m_left = 0; m_snoozes = 0; m_bell = 0;
  endtask

  task automatic start_ring();
    m_mode = M_RING; m_rung = 0; m_bell = 1;
  endtask

  task automatic model_step();
    bit matched, trig;
    matched = alm_en_i && (cur_hh_i == alm_hh_i) && (cur_mm_i == alm_mm_i);
    trig = matched && !m_prev_match;
    m_prev_match = matched;
    case (m_mode)
      M_IDLE:   if (alm_en_i) go_quiet(M_ARMED); else if (set_req_i) m_mode = M_SET;
      M_ARMED:  if (!alm_en_i) go_quiet(M_IDLE); else if (set_req_i) m_mode = M_SET;
                else if (trig) start_ring();
      M_SET:    if (set_req_i) go_quiet(alm_en_i ? M_ARMED : M_IDLE);
      M_RING: begin
        if (!alm_en_i) go_quiet(M_IDLE);
        else if (stop_i) go_quiet(M_ARMED);
        else if (snooze_i && m_snoozes < MS) begin
          m_snoozes++; m_left = SS; m_mode = M_SNOOZE;
        end else if (tick_1s_i) begin
          m_rung++;
          if (m_rung >= RT) go_quiet(M_ARMED); else m_bell = !m_bell;
        end
      end
      M_SNOOZE: begin
        if (!alm_en_i) go_quiet(M_IDLE);
        else if (stop_i) go_quiet(M_ARMED);
        else if (tick_1s_i) begin
          if (m_left == 1) start_ring(); else m_left--;
        end
      end
      default: go_quiet(M_IDLE);
    endcase
  endtask

  function automatic logic [1:0] exp_disp();
    case (m_mode)
      M_SET:    return 2'b01;
      M_RING:   return 2'b10;
      M_SNOOZE: return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  // One clock: model consumes the inputs seen at the edge, pulses drop afterwards.
  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    tick_1s_i = 0; set_req_i = 0; snooze_i = 0; stop_i = 0;
  endtask

  task automatic set_time(input int hh, input int mm);
    cur_hh_i = 5'(hh); cur_mm_i = 6'(mm);
  endtask

  task automatic test_reset();
    model_reset();
    alm_hh_i = 5'd7; alm_mm_i = 6'd30; set_time(7, 29);
    #12;
    n_cmp++; if (disp_sel_o !== 2'b00) begin n_err++; $display("FAIL reset_disp got=%b exp=00", disp_sel_o); end
    n_cmp++; if (ring_o !== 1'b0) begin n_err++; $display("FAIL reset_ring got=%b exp=0", ring_o); end
    n_cmp++; if (snz_left_o !== '0) begin n_err++; $display("FAIL reset_left got=%0d exp=0", snz_left_o); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst = 1;
  endtask

  task automatic test_ring_start();
    alm_en_i = 1;
    step();
    n_cmp++; if (disp_sel_o !== 2'b00) begin n_err++; $display("FAIL armed_disp got=%b exp=00", disp_sel_o); end
    set_time(7, 30);
    step();
    n_cmp++; if (disp_sel_o !== 2'b10) begin n_err++; $display("FAIL ring_disp got=%b exp=10", disp_sel_o); end
    n_cmp++; if (ring_o !== 1'b1) begin n_err++; $display("FAIL ring_first got=%b exp=1", ring_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (ring_o !== 1'b0) begin n_err++; $display("FAIL ring_toggle1 got=%b exp=0", ring_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (ring_o !== 1'b1) begin n_err++; $display("FAIL ring_toggle2 got=%b exp=1", ring_o); end
  endtask

  task automatic test_timeout();
    tick_1s_i = 1; step();
    n_cmp++; if (ring_o !== 1'b0 || disp_sel_o !== 2'b10) begin n_err++; $display("FAIL tick3 got=%b/%b exp=0/10", ring_o, disp_sel_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b00 || ring_o !== 1'b0) begin n_err++; $display("FAIL timeout got=%b/%b exp=00/0", disp_sel_o, ring_o); end
    for (int i = 0; i < 5; i++) begin tick_1s_i = 1; step(); end
    n_cmp++; if (disp_sel_o !== 2'b00 || ring_o !== 1'b0) begin n_err++; $display("FAIL no_rering got=%b/%b exp=00/0", disp_sel_o, ring_o); end
  endtask

  task automatic retrigger();
    set_time(7, 31); step();
    set_time(7, 30); step();
  endtask

  task automatic test_snooze();
    retrigger();
    snooze_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b11 || snz_left_o !== 9'd3) begin n_err++; $display("FAIL snooze_enter got=%b/%0d exp=11/3", disp_sel_o, snz_left_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (snz_left_o !== 9'd2) begin n_err++; $display("FAIL snooze_left2 got=%0d exp=2", snz_left_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (snz_left_o !== 9'd1) begin n_err++; $display("FAIL snooze_left1 got=%0d exp=1", snz_left_o); end
    tick_1s_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b10 || ring_o !== 1'b1) begin n_err++; $display("FAIL snooze_expire got=%b/%b exp=10/1", disp_sel_o, ring_o); end
    snooze_i = 1; tick_1s_i = 1; step();
    n_cmp++; if (snz_left_o !== 9'd3 || dbg_snz_cnt !== 2'd2) begin n_err++; $display("FAIL snooze_tick_tie got=%0d/%0d exp=3/2", snz_left_o, dbg_snz_cnt); end
    for (int i = 0; i < 3; i++) begin tick_1s_i = 1; step(); end
    snooze_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b10 || dbg_snz_cnt !== 2'd2) begin n_err++; $display("FAIL snooze_limit got=%b/%0d exp=10/2", disp_sel_o, dbg_snz_cnt); end
  endtask

  task automatic test_stop_and_snooze();
    stop_i = 1; snooze_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b00 || ring_o !== 1'b0) begin n_err++; $display("FAIL stop_wins got=%b/%b exp=00/0", disp_sel_o, ring_o); end
    n_cmp++; if (dbg_snz_cnt !== 2'd0) begin n_err++; $display("FAIL stop_clears_cnt got=%0d exp=0", dbg_snz_cnt); end
  endtask

  task automatic test_alm_en_fall();
    retrigger();
    snooze_i = 1; step();
    tick_1s_i = 1; step();
    alm_en_i = 0; step();
    n_cmp++; if (disp_sel_o !== 2'b00 || ring_o !== 1'b0 || snz_left_o !== '0) begin n_err++; $display("FAIL en_fall got=%b/%b/%0d exp=00/0/0", disp_sel_o, ring_o, snz_left_o); end
    set_req_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b01) begin n_err++; $display("FAIL set_enter got=%b exp=01", disp_sel_o); end
    set_req_i = 1; step();
    n_cmp++; if (disp_sel_o !== 2'b00) begin n_err++; $display("FAIL set_exit got=%b exp=00", disp_sel_o); end
  endtask

  task automatic test_set_no_ring();
    set_time(7, 29); alm_en_i = 1; step();
    set_req_i = 1; step();
    set_time(7, 30); step(); step(); step();
    n_cmp++; if (disp_sel_o !== 2'b01 || ring_o !== 1'b0) begin n_err++; $display("FAIL set_hold got=%b/%b exp=01/0", disp_sel_o, ring_o); end
    set_req_i = 1; step();
    step(); step(); step();
    n_cmp++; if (disp_sel_o !== 2'b00 || ring_o !== 1'b0) begin n_err++; $display("FAIL set_no_ring got=%b/%b exp=00/0", disp_sel_o, ring_o); end
  endtask

  task automatic test_async_reset();
    retrigger();
    n_cmp++; if (ring_o !== 1'b1) begin n_err++; $display("FAIL pre_reset_ring got=%b exp=1", ring_o); end
    #2 rst = 0;
    #1;
    n_cmp++; if (ring_o !== 1'b0 || disp_sel_o !== 2'b00 || snz_left_o !== '0 || dbg_state !== ST_IDLE)
      begin n_err++; $display("FAIL async_reset got=%b/%b/%0d/%0d exp=0/00/0/0", ring_o, disp_sel_o, snz_left_o, dbg_state); end
    #2 rst = 1;
    model_reset();
  endtask

  task automatic test_random();
    alm_en_i = 1;
    for (int i = 0; i < 1500; i++) begin
      if (alm_en_i) alm_en_i = ($urandom_range(0, 99) >= 2);
      else          alm_en_i = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 12) cur_mm_i = 6'($urandom_range(29, 31));
      cur_hh_i  = ($urandom_range(0, 99) < 4) ? 5'd8 : 5'd7;
      tick_1s_i = ($urandom_range(0, 99) < 35);
      set_req_i = ($urandom_range(0, 99) < 3);
      snooze_i  = ($urandom_range(0, 99) < 10);
      stop_i    = ($urandom_range(0, 99) < 3);
      step();
      n_cmp++; if (disp_sel_o !== exp_disp()) begin n_err++; $display("FAIL rnd_disp cyc=%0d got=%b exp=%b", i, disp_sel_o, exp_disp()); end
      n_cmp++; if (ring_o !== (m_mode == M_RING && m_bell)) begin n_err++; $display("FAIL rnd_ring cyc=%0d got=%b exp=%b", i, ring_o, (m_mode == M_RING && m_bell)); end
      n_cmp++; if (snz_left_o !== ((m_mode == M_SNOOZE) ? CW'(m_left) : '0)) begin n_err++; $display("FAIL rnd_left cyc=%0d got=%0d exp=%0d", i, snz_left_o, (m_mode == M_SNOOZE) ? m_left : 0); end
      n_cmp++; if (dbg_snz_cnt !== 2'(m_snoozes)) begin n_err++; $display("FAIL rnd_snz_cnt cyc=%0d got=%0d exp=%0d", i, dbg_snz_cnt, m_snoozes); end
    end
  endtask

  initial begin
    test_reset();
    test_ring_start();
    test_timeout();
    test_snooze();
    test_stop_and_snooze();
    test_alm_en_fall();
    test_set_no_ring();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
